// File: rtl/apb_uart_rx_ctrl_pkg.sv
// rtl/apb_uart_rx_ctrl_pkg.sv - register map and bit positions for the UART RX controller
package uart_pkg;

  localparam logic [3:0] UART_RX_DATA_OFS = 4'h0;
  localparam logic [3:0] UART_RX_STAT_OFS = 4'h4;
  localparam logic [3:0] UART_RX_CTRL_OFS = 4'h8;

  typedef enum logic [1:0] {
    REG_DATA = 2'd0,
    REG_STAT = 2'd1,
    REG_CTRL = 2'd2,
    REG_RSVD = 2'd3
  } reg_sel_e;

  localparam int STAT_EMPTY_BIT = 0;
  localparam int STAT_FULL_BIT  = 1;
  localparam int STAT_OVR_BIT   = 2;
  localparam int STAT_COUNT_LSB = 8;
  localparam int STAT_COUNT_W   = 8;

  localparam int CTRL_RX_EN_BIT  = 0;
  localparam int CTRL_IRQ_EN_BIT = 1;

  // Only the word index is decoded; byte lanes inside a register alias.
  function automatic reg_sel_e decode_reg(input logic [3:0] addr);
    reg_sel_e sel;
    case (addr[3:2])
      UART_RX_DATA_OFS[3:2]: sel = REG_DATA;
      UART_RX_STAT_OFS[3:2]: sel = REG_STAT;
      UART_RX_CTRL_OFS[3:2]: sel = REG_CTRL;
      default:               sel = REG_RSVD;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/apb_uart_rx_ctrl_if.sv
// rtl/apb_uart_rx_ctrl_if.sv - APB bus bundle between decoder and UART RX controller
interface apb_uart_rx_ctrl_if #(
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] PADDR;
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [31:0]       PWDATA;
  logic [31:0]       PRDATA;
  logic              PREADY;

  modport master (
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    input  PRDATA, PREADY
  );

  modport slave (
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    output PRDATA, PREADY
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - byte FIFO holding received characters until software drains them
module uart_rx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     PCLK,
  input  logic                     PRESET,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_pop;
  logic          do_push;

  // A pop on an empty FIFO is ignored; a pop on a full FIFO frees the slot
  // that a same-cycle push then takes.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);
  assign dout  = mem[rd_ptr];

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge PCLK) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/apb_uart_rx_ctrl.sv
// rtl/apb_uart_rx_ctrl.sv - APB register front end buffering UART receiver bytes with overrun and irq
module apb_uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 4
) (
  input  logic                     PCLK,
  input  logic                     PRESET,
  apb_uart_rx_ctrl_if.slave        apb,
  input  logic [7:0]               rx_data,
  input  logic                     rx_done,
  output logic                     irq
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [ADDR_W-1:0] paddr;
  reg_sel_e          sel;
  logic              rd_acc;
  logic              wr_acc;
  logic              rx_en;
  logic              irq_en;
  logic              overrun;
  logic              fifo_push;
  logic              fifo_pop;
  logic              empty;
  logic              full;
  logic [7:0]        head;
  logic [CNT_W-1:0]  count;
  logic [7:0]        count_b;
  logic              ovr_set;
  logic              ovr_clr;
  logic [31:0]       prdata;
  logic              unused_bits;

  assign paddr  = apb.PADDR;
  assign sel    = decode_reg(paddr[3:0]);
  assign rd_acc = apb.PSEL && apb.PENABLE && !apb.PWRITE;
  assign wr_acc = apb.PSEL && apb.PENABLE && apb.PWRITE;

  assign fifo_push = rx_done && rx_en;
  assign fifo_pop  = rd_acc && (sel == REG_DATA);

  // A full FIFO only loses the byte when no read frees a slot that cycle.
  assign ovr_set = fifo_push && full && !fifo_pop;
  assign ovr_clr = wr_acc && (sel == REG_STAT) && apb.PWDATA[STAT_OVR_BIT];

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .push   (fifo_push),
    .pop    (fifo_pop),
    .din    (rx_data),
    .dout   (head),
    .empty  (empty),
    .full   (full),
    .count  (count)
  );

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      rx_en   <= 1'b0;
      irq_en  <= 1'b0;
      overrun <= 1'b0;
      irq     <= 1'b0;
    end else begin
      if (wr_acc && (sel == REG_CTRL)) begin
        rx_en  <= apb.PWDATA[CTRL_RX_EN_BIT];
        irq_en <= apb.PWDATA[CTRL_IRQ_EN_BIT];
      end
      if (ovr_set)      overrun <= 1'b1;
      else if (ovr_clr) overrun <= 1'b0;
      irq <= irq_en && (!empty || overrun);
    end
  end

  assign count_b = STAT_COUNT_W'(count);

  // Read data reflects state before this access's edge updates it.
  always_comb begin
    prdata = '0;
    if (rd_acc) begin
      case (sel)
        REG_DATA: if (!empty) prdata[7:0] = head;
        REG_STAT: begin
          prdata[STAT_EMPTY_BIT] = empty;
          prdata[STAT_FULL_BIT]  = full;
          prdata[STAT_OVR_BIT]   = overrun;
          prdata[STAT_COUNT_LSB +: STAT_COUNT_W] = count_b;
        end
        REG_CTRL: begin
          prdata[CTRL_RX_EN_BIT]  = rx_en;
          prdata[CTRL_IRQ_EN_BIT] = irq_en;
        end
        default: prdata = '0;
      endcase
    end
  end

  assign apb.PRDATA = prdata;
  assign apb.PREADY = 1'b1;

  assign unused_bits = ^{apb.PWDATA, paddr};

endmodule

// File: tb/tb_apb_uart_rx_ctrl.sv
// tb/tb_apb_uart_rx_ctrl.sv - scoreboard bench for the APB UART RX controller
module tb_apb_uart_rx_ctrl;

  localparam logic [3:0] A_DATA = 4'h0;
  localparam logic [3:0] A_STAT = 4'h4;
  localparam logic [3:0] A_CTRL = 4'h8;
  localparam logic [3:0] A_RSVD = 4'hC;

  localparam int K_READ = 0;
  localparam int K_IRQ  = 1;
  localparam int K_IDLE = 2;

  typedef struct {
    int          kind;
    string       name;
    logic [31:0] exp;
  } exp_t;

  logic       PCLK = 1'b0;
  logic       PRESET = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_done = 1'b0;
  logic       irq;
  int         probe = 0;

  exp_t sbq[$];
  int   checks = 0;
  int   passed = 0;

  apb_uart_rx_ctrl_if #(.ADDR_W(4)) bus ();

  apb_uart_rx_ctrl #(
    .FIFO_DEPTH (8),
    .ADDR_W     (4)
  ) dut (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .apb     (bus),
    .rx_data (rx_data),
    .rx_done (rx_done),
    .irq     (irq)
  );

  always #5 PCLK = ~PCLK;

  task automatic compare(input int kind, input logic [31:0] act);
    exp_t e;
    checks++;
    if (sbq.size() == 0) begin
      $display("FAIL unexpected_output kind=%0d actual=0x%08h required=none", kind, act);
    end else begin
      e = sbq.pop_front();
      if (e.kind != kind || act !== e.exp)
        $display("FAIL %s kind=%0d/%0d actual=0x%08h required=0x%08h", e.name, kind, e.kind, act, e.exp);
      else
        passed++;
    end
  endtask

  always @(negedge PCLK) begin
    if (bus.PSEL && bus.PENABLE && !bus.PWRITE) compare(K_READ, bus.PRDATA);
    if (probe == K_IRQ)  compare(K_IRQ, {31'b0, irq});
    if (probe == K_IDLE) compare(K_IDLE, bus.PRDATA);
  end

  task automatic push_exp(input int kind, input string n, input logic [31:0] e);
    exp_t t;
    t.kind = kind;
    t.name = n;
    t.exp  = e;
    sbq.push_back(t);
  endtask

  task automatic apb_read(input logic [3:0] a, input string n, input logic [31:0] e,
                          input bit with_rx = 1'b0, input logic [7:0] b = 8'h00);
    push_exp(K_READ, n, e);
    @(posedge PCLK); #1;
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = a;
    @(posedge PCLK); #1;
    bus.PENABLE = 1'b1;
    if (with_rx) begin rx_done = 1'b1; rx_data = b; end
    @(posedge PCLK); #1;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; rx_done = 1'b0;
  endtask

  task automatic apb_write(input logic [3:0] a, input logic [31:0] d);
    @(posedge PCLK); #1;
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1; bus.PADDR = a; bus.PWDATA = d;
    @(posedge PCLK); #1;
    bus.PENABLE = 1'b1;
    @(posedge PCLK); #1;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
  endtask

  task automatic rx_pulse(input logic [7:0] b);
    @(posedge PCLK); #1;
    rx_done = 1'b1; rx_data = b;
    @(posedge PCLK); #1;
    rx_done = 1'b0;
  endtask

  // Samples at the next falling edge from the current time.
  task automatic chk_now(input int kind, input string n, input logic [31:0] e);
    push_exp(kind, n, e);
    probe = kind;
    @(negedge PCLK); #1;
    probe = 0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
    bus.PADDR = 4'h0; bus.PWDATA = 32'h0;
    repeat (3) @(posedge PCLK);
    #1 PRESET = 1'b0;

    // Reset state
    chk_now(K_IRQ,  "rst_irq", 32'h0);
    chk_now(K_IDLE, "rst_prdata_idle", 32'h0);
    apb_read(A_STAT, "rst_status", 32'h0000_0001);
    apb_read(A_CTRL, "rst_ctrl", 32'h0);
    apb_read(A_DATA, "rst_data_empty", 32'h0);
    apb_read(A_RSVD, "rst_rsvd", 32'h0);

    // Three bytes in, drained in order, irq latency on last pop
    apb_write(A_CTRL, 32'h3);
    apb_read(A_CTRL, "t1_ctrl", 32'h3);
    rx_pulse(8'h41); rx_pulse(8'h42); rx_pulse(8'h43);
    apb_read(A_STAT, "t1_status3", 32'h0000_0300);
    chk_now(K_IRQ, "t1_irq_set", 32'h1);
    apb_read(A_DATA, "t1_d41", 32'h41);
    apb_read(A_DATA, "t1_d42", 32'h42);
    apb_read(A_DATA, "t1_d43", 32'h43);
    chk_now(K_IRQ, "t1_irq_hold", 32'h1);
    chk_now(K_IRQ, "t1_irq_drop", 32'h0);
    apb_read(A_STAT, "t1_status_empty", 32'h0000_0001);
    apb_write(A_RSVD, 32'hFFFF_FFFF);
    apb_read(A_CTRL, "t1_rsvd_write_ignored", 32'h3);

    // Overflow: nine bytes into eight slots
    for (int i = 0; i < 9; i++) rx_pulse(8'(i));
    apb_read(A_STAT, "t2_status_full_ovr", 32'h0000_0806);
    for (int i = 0; i < 8; i++) apb_read(A_DATA, $sformatf("t2_d%0d", i), 32'(i));
    apb_read(A_STAT, "t2_status_empty_ovr", 32'h0000_0005);
    chk_now(K_IRQ, "t2_irq_ovr", 32'h1);
    apb_write(A_STAT, 32'h4);
    apb_read(A_STAT, "t2_status_ovr_clr", 32'h0000_0001);
    chk_now(K_IRQ, "t2_irq_clr", 32'h0);

    // Full FIFO with push during a pop: no overrun, byte lands last
    for (int i = 0; i < 8; i++) rx_pulse(8'h60 + 8'(i));
    apb_read(A_DATA, "t3_d60_push", 32'h60, 1'b1, 8'hAA);
    apb_read(A_STAT, "t3_status_full", 32'h0000_0802);
    for (int i = 1; i < 8; i++) apb_read(A_DATA, $sformatf("t3_d6%0d", i), 32'h60 + 32'(i));
    apb_read(A_DATA, "t3_dAA", 32'hAA);
    apb_read(A_STAT, "t3_status_empty", 32'h0000_0001);

    // Receiver disabled: byte discarded, empty read harmless
    apb_write(A_CTRL, 32'h2);
    rx_pulse(8'h55);
    apb_read(A_STAT, "t4_status", 32'h0000_0001);
    chk_now(K_IRQ, "t4_irq", 32'h0);
    apb_read(A_DATA, "t4_data_empty", 32'h0);
    apb_read(A_STAT, "t4_status_after", 32'h0000_0001);
    apb_read(A_CTRL, "t4_ctrl", 32'h2);

    // Pointer wrap with overlapping push and pop
    apb_write(A_CTRL, 32'h3);
    for (int i = 0; i < 4; i++) rx_pulse(8'h10 + 8'(i));
    for (int i = 0; i < 8; i++)
      apb_read(A_DATA, $sformatf("t5_dw%0d", i), 32'h10 + 32'(i), 1'b1, 8'h14 + 8'(i));
    apb_read(A_STAT, "t5_status4", 32'h0000_0400);
    for (int i = 8; i < 12; i++) apb_read(A_DATA, $sformatf("t5_dt%0d", i), 32'h10 + 32'(i));
    apb_read(A_STAT, "t5_status_empty", 32'h0000_0001);
    apb_read(A_DATA, "t5_empty_pop_push", 32'h0, 1'b1, 8'h77);
    apb_read(A_STAT, "t5_status1", 32'h0000_0100);
    apb_read(A_DATA, "t5_d77", 32'h77);

    // Reset with four bytes queued and overrun set
    for (int i = 0; i < 9; i++) rx_pulse(8'h80 + 8'(i));
    for (int i = 0; i < 4; i++) apb_read(A_DATA, $sformatf("t6_d8%0d", i), 32'h80 + 32'(i));
    apb_read(A_STAT, "t6_status_pre", 32'h0000_0404);
    chk_now(K_IRQ, "t6_irq_pre", 32'h1);
    @(posedge PCLK); #1;
    rx_done = 1'b1; rx_data = 8'h99; PRESET = 1'b1;
    chk_now(K_IRQ, "t6_irq_rst", 32'h0);
    apb_read(A_STAT, "t6_status_in_rst", 32'h0000_0001);
    apb_read(A_CTRL, "t6_ctrl_in_rst", 32'h0);
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    apb_read(A_STAT, "t6_status_post", 32'h0000_0001);
    apb_read(A_CTRL, "t6_ctrl_post", 32'h0);
    apb_read(A_DATA, "t6_data_post", 32'h0);
    chk_now(K_IRQ, "t6_irq_post", 32'h0);

    for (int i = 0; i < 20 && sbq.size() != 0; i++) @(posedge PCLK);
    while (sbq.size() != 0) begin
      exp_t e;
      e = sbq.pop_front();
      checks++;
      $display("FAIL %s actual=never_observed required=0x%08h", e.name, e.exp);
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
